// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state encoding, default widths and grant-index sizing for reg_port_arbiter
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 1;
  function automatic int gid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = |req;
    // scan the rotated order backwards so the closest requester at/after ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: round-robin sharing of one register-file port, accept/issue/respond sequencing
// Optional REG_ARB_LOCK_EN adds req_lock to regrant a locked winner (read-modify-write).
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int IW = gid_w(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rf_en,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic                       busy,
  output logic [IW-1:0]              grant_id
);
  state_t              state;
  logic [IW-1:0]       rr_ptr, win, pick_idx, next_ptr;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_any, cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata, rsp_q, rd_val;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid), .ptr(rr_ptr), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
  );

  always_comb begin
    next_ptr = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef REG_ARB_LOCK_EN
    next_ptr = req_lock[win] ? win : next_ptr;
`endif
  end

  // rf_rdata only arrives in RESP, so the response data is passed through then and held afterwards
  assign rd_val    = cmd_we ? '0 : rf_rdata;
  assign req_ready = (rst && state == IDLE) ? pick_grant : '0;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << win) : '0;
  assign rsp_rdata = (state == RESP) ? rd_val : rsp_q;
  assign rf_en     = state == ISSUE;
  assign rf_we     = rf_en ? cmd_we : 1'b0;
  assign rf_addr   = rf_en ? cmd_addr : '0;
  assign rf_wdata  = rf_en ? cmd_wdata : '0;
  assign busy      = state != IDLE;
  assign grant_id  = win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      win <= '0;
      cmd_we <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      rsp_q <= '0;
    end else if (state == IDLE) begin
      if (pick_any) begin
        state <= ISSUE;
        win <= pick_idx;
        cmd_we <= req_we[pick_idx];
        cmd_addr <= req_addr[pick_idx * ADDR_W +: ADDR_W];
        cmd_wdata <= req_wdata[pick_idx * DATA_W +: DATA_W];
      end
    end else if (state == ISSUE) begin
      state <= RESP;
    end else begin
      state <= IDLE;
      rsp_q <= rd_val;
      rr_ptr <= next_ptr;
    end
  end
endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter: directed checks of accept/issue/respond timing, round-robin order, reset abort, lock
module tb_reg_port_arbiter;
  logic       clk = 0, rst = 0;
  logic [1:0] req_valid = 0, req_we = 0, req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic [3:0] rf_rdata = 4'h5;
`ifdef REG_ARB_LOCK_EN
  logic [1:0] req_lock = 0;
`endif
  logic [1:0] req_ready, rsp_valid;
  logic [3:0] rsp_rdata, rf_wdata;
  logic       rf_en, rf_we, busy;
  logic [0:0] rf_addr, grant_id;
  int total = 0, bad = 0;

  reg_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rf_en(rf_en),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, " rf_en"}, 32'(rf_en), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // single transaction from requester i; expected rdata is 0 for writes
  task automatic tx(input int i, input logic we, input logic a, input logic [3:0] d,
                    input logic [3:0] exp_rd);
    @(posedge clk); #1;
    req_valid[i] = 1; req_we[i] = we; req_addr[i] = a; req_wdata[i*4 +: 4] = d;
    @(negedge clk);
    chk("tx ready", 32'(req_ready), 32'(1 << i));
    @(posedge clk); #1;
    req_valid[i] = 0;
    @(negedge clk);
    chk("tx rf_en", 32'(rf_en), 1);
    chk("tx rf_we", 32'(rf_we), 32'(we));
    chk("tx rf_addr", 32'(rf_addr), 32'(a));
    chk("tx rf_wdata", 32'(rf_wdata), 32'(we ? d : 4'h0));
    chk("tx busy", 32'(busy), 1);
    chk("tx grant_id", 32'(grant_id), 32'(i));
    chk("tx early rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("tx rsp_valid", 32'(rsp_valid), 32'(1 << i));
    chk("tx rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("tx rf_en off", 32'(rf_en), 0);
  endtask

  initial begin
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    idle_chk("in reset");
    chk("in reset grant_id", 32'(grant_id), 0);
    chk("in reset rsp_rdata", 32'(rsp_rdata), 0);
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle_chk("idle");
    end
    tx(0, 1, 1, 4'hA, 4'h0);
    tx(1, 0, 0, 4'h0, 4'h5);
    chk("grant_id held", 32'(grant_id), 1);
    @(posedge clk); #1;
    req_valid = 2'b11; req_we = 0; req_addr = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr order", 32'(req_ready), 32'((k % 2) ? 2 : 1));
      @(negedge clk);
      @(negedge clk);
      chk("rr rsp", 32'(rsp_valid), 32'((k % 2) ? 2 : 1));
    end
    @(posedge clk); #1;
    req_valid = 0;
    tx(0, 1, 0, 4'h3, 4'h0);
    @(posedge clk); #1;
    req_valid[1] = 1;
    @(negedge clk);
    chk("abort accept", 32'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("abort issue", 32'(rf_en), 1);
    rst = 0;
    #1;
    chk("abort rf_en", 32'(rf_en), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort rf_addr", 32'(rf_addr), 0);
    @(negedge clk);
    chk("abort no rsp", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("after abort rsp", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("ptr reset", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("ptr reset rsp", 32'(rsp_valid), 1);
`ifdef REG_ARB_LOCK_EN
    tx(1, 0, 1, 4'h0, 4'h5);
    @(posedge clk); #1;
    req_lock = 2'b01; req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock grant", 32'(req_ready), 1);
      if (k == 2) begin
        @(posedge clk); #1;
        req_lock = 0;
      end
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    chk("unlock grant", 32'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 0;
`endif
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Shares the single register-file access port (read or write) among NUM_REQ requesters, e.g. the control-unit writeback path and a debug/host loader.
- Round-robin arbitration; one transaction in flight at a time.
- Three-state sequencer: accept, issue, respond.
- Sits between the requesters and the registers module; owns every rf_* signal.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 4, register data width.
- ADDR_W, 1, register address width (2 registers).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- req_valid  in  NUM_REQ  per-requester request pending
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- rf_en  out  1  register-port strobe
- rf_we  out  1  register-port write enable
- rf_addr  out  ADDR_W  register-port address
- rf_wdata  out  DATA_W  register-port write data
- rf_rdata  in  DATA_W  register-port read data, valid the cycle after rf_en
- busy  out  1  transaction in flight
- grant_id  out  $clog2(NUM_REQ) (min 1)  current or last winner index

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0; all outputs 0 (req_ready, rsp_valid, rsp_rdata, rf_*, busy, grant_id).
- Reset mid-transaction aborts the transaction: rf_en drops immediately and no rsp_valid is issued. Requesters re-request after reset.
- State IDLE:
  - If any req_valid: winner = first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready[winner]=1 this cycle (combinational from req_valid and state).
  - Latch we/addr/wdata and winner; go to ISSUE.
  - If no req_valid: stay in IDLE.
- State ISSUE: rf_en=1, rf_we/rf_addr/rf_wdata from latched command for exactly one cycle; busy=1; go to RESP.
- State RESP:
  - Read: rsp_rdata <= rf_rdata. Write: rsp_rdata <= 0.
  - rsp_valid[winner]=1 for one cycle (registered; rsp_rdata is valid in the same cycle).
  - rr_ptr <= (winner+1) mod NUM_REQ; go to IDLE.
- Latency and throughput:
  - Accept in cycle T; rf_en in T+1; rsp_valid in T+2.
  - Maximum throughput is one transaction per 3 cycles.
- Handshake rules:
  - A requester holds req_valid and its command stable until it sees req_ready.
  - Dropping req_valid before req_ready is legal; nothing is issued for it.
  - After req_ready, requester inputs are ignored until that requester's rsp_valid.
- Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
- Simultaneous requests: only one winner per accept cycle; losers stay pending.
- rr_ptr wrap: (NUM_REQ-1)+1 -> 0.
- busy=1 in ISSUE and RESP, 0 in IDLE.
- grant_id updates at accept and holds its value through IDLE.
- Unused rf_* fields are driven 0 when rf_en=0.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock[NUM_REQ].
  - If req_lock[winner]=1 in RESP, rr_ptr <= winner (not advanced), so a requester holding lock and valid is regranted next, e.g. for read-modify-write.
  - Lock is released when req_lock drops; arbitration resumes from winner+1 on the next RESP.
- When undefined: no req_lock port; pure round-robin.

Decomposition:
- Package reg_arb_pkg:
  - State enum typedef {IDLE, ISSUE, RESP} (2-bit).
  - Default width constants DATA_W=4, ADDR_W=1.
  - A function that returns the ceil-log2 width of grant_id.
- One sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: grant one-hot, grant index, any.

Test Plan:
- Reset release, no requests, 10 cycles -> all outputs 0, busy=0, state stays IDLE.
- Req0 write addr=1 data=4'hA -> req_ready[0] at T, rf_en=1/rf_we=1/rf_addr=1/rf_wdata=A at T+1, rsp_valid[0] at T+2 with rsp_rdata=0.
- Req1 read addr=0 with rf_rdata=4'h5 -> rsp_valid[1] at T+2, rsp_rdata=5.
- Both requesters continuously valid for 6 transactions -> grant order 0,1,0,1,0,1; no requester is granted twice in a row.
- rst=0 asserted during ISSUE -> rf_en=0 within the same cycle, no rsp_valid, rr_ptr=0 after release.
- REG_ARB_LOCK_EN: req0 with req_lock=1, both valid -> grants 0,0,0; req_lock drops -> next grant 1.
